// File: rtl/wishbone_master.sv
// Classic single-cycle Wishbone B3 initiator: one user request becomes one bus cycle,
// ending in a done or timeout pulse followed by a one-cycle idle gap on the bus.
module wishbone_master #(
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 15
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_i,
    input  logic              req_we_i,
    input  logic [ADDR_W-1:0] req_adr_i,
    input  logic [DATA_W-1:0] req_dat_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic [ADDR_W-1:0] adr_o,
    output logic              we_o,
    output logic [DATA_W-1:0] dat_o,
    output logic              cyc_o,
    output logic              stb_o,
    input  logic [DATA_W-1:0] dat_i,
    input  logic              ack_i,
    output logic [1:0]        fsm_state
);

    // Handshake: a request is taken only when req_i is high at an edge in IDLE (busy_o low);
    // a bus cycle completes at the first edge in BUS that sees ack_i high with cyc_o/stb_o high.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } state_t;

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                timeout_hit;
    logic                busy_d, done_d, err_d, we_d, cyc_d, stb_d;
    logic [DATA_W-1:0]   rdata_d, dat_d;
    logic [ADDR_W-1:0]   adr_d;

    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_LAST);
    assign fsm_state   = state_q;

    // State and every output live in this one register bank, so all outputs are registered.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_o  <= 1'b0;
            done_o  <= 1'b0;
            err_o   <= 1'b0;
            rdata_o <= '0;
            adr_o   <= '0;
            we_o    <= 1'b0;
            dat_o   <= '0;
            cyc_o   <= 1'b0;
            stb_o   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_o  <= busy_d;
            done_o  <= done_d;
            err_o   <= err_d;
            rdata_o <= rdata_d;
            adr_o   <= adr_d;
            we_o    <= we_d;
            dat_o   <= dat_d;
            cyc_o   <= cyc_d;
            stb_o   <= stb_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_i) state_d = BUS;
            BUS: begin
                if (ack_i)            state_d = DONE;
                else if (timeout_hit) state_d = ERR;
            end
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next values for the registered outputs; ack wins over a simultaneous timeout.
    always_comb begin
        cnt_d   = cnt_q;
        busy_d  = (state_d != IDLE);
        done_d  = 1'b0;
        err_d   = 1'b0;
        rdata_d = rdata_o;
        adr_d   = adr_o;
        we_d    = we_o;
        dat_d   = dat_o;
        cyc_d   = 1'b0;
        stb_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_i) begin
                    adr_d = req_adr_i;
                    we_d  = req_we_i;
                    dat_d = req_dat_i;
                    cyc_d = 1'b1;
                    stb_d = 1'b1;
                    cnt_d = '0;
                end
            end
            BUS: begin
                if (ack_i) begin
                    done_d = 1'b1;
                    if (!we_o) rdata_d = dat_i;
                end else if (timeout_hit) begin
                    err_d = 1'b1;
                end else begin
                    cyc_d = 1'b1;
                    stb_d = 1'b1;
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: ;
        endcase
    end

endmodule
